uart_loopback_fifo: RTL and testbench

UART_LOOPBACK_FIFO -- requirements
Module: uart_loopback_fifo

---
 rtl/uart_loopback_fifo.sv | 310 +++++++++++++++++++++++++++++++
 tb/tb_uart_loopback_fifo.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_loopback_fifo.sv
// rtl/uart_loopback_fifo.sv - UART receiver feeding a FIFO that drains back out through a UART transmitter
`timescale 1ns/1ps
module uart_loopback_fifo #(
    parameter int CLK_FREQUENCY = 12_000_000,
    parameter int BAUD          = 115_200,
    parameter int DATA_BITS     = 8,
    parameter int PARITY        = 0,
    parameter int STOP_BITS     = 1,
    parameter int FIFO_DEPTH    = 16
) (
    input  logic                          clk_12mhz,
    input  logic                          reset,
    input  logic                          rxd,
    input  logic                          tx_hold,
    input  logic                          clear_err,
    output logic                          txd,
    output logic [7:0]                    led,
    output logic                          framing_err,
    output logic                          parity_err,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int CLKS_PER_BIT = CLK_FREQUENCY / BAUD;
    localparam int CW           = $clog2(CLKS_PER_BIT + 1);
    localparam int AW           = $clog2(FIFO_DEPTH);
    localparam int CNTW         = AW + 1;

    localparam logic [CW-1:0]   BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]   HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]      IDX_LAST  = 3'(DATA_BITS - 1);
    localparam logic            STOP_LAST = (STOP_BITS == 2);
    localparam logic            HAS_PAR   = (PARITY != 0);
    localparam logic [AW-1:0]   PTR_ONE   = AW'(1);
    localparam logic [CNTW-1:0] CNT_ONE   = CNTW'(1);
    localparam logic [CNTW-1:0] CNT_FULL  = CNTW'(FIFO_DEPTH);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    function automatic logic par_of(input logic [DATA_BITS-1:0] d);
        return (PARITY == 2) ? ~^d : ^d;
    endfunction

    logic                 rx_meta;
    logic                 rx_s;
    logic [1:0]           sync_vld;
    logic                 rx_armed;
    logic [2:0]           rx_state;
    logic [CW-1:0]        rx_cnt;
    logic [2:0]           rx_idx;
    logic [DATA_BITS-1:0] rx_shift;
    logic                 rx_par_bit;
    logic                 rx_push;
    logic [DATA_BITS-1:0] rx_data;

    logic                 rx_stop_sample;
    logic                 frame_set;
    logic                 par_set;
    logic                 rx_good;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic                 push;
    logic                 pop;
    logic                 ovf_set;

    logic [2:0]           tx_state;
    logic [CW-1:0]        tx_cnt;
    logic [2:0]           tx_idx;
    logic                 tx_stop_idx;
    logic [DATA_BITS-1:0] tx_shift;
    logic                 tx_par;

    always_ff @(posedge clk_12mhz) begin
        if (reset) begin
            rx_meta  <= 1'b1;
            rx_s     <= 1'b1;
            sync_vld <= 2'b00;
        end else begin
            rx_meta  <= rxd;
            rx_s     <= rx_meta;
            sync_vld <= {sync_vld[0], 1'b1};
        end
    end

    // A start bit is only believed after a real high has come through the
    // synchronizer, both after reset and after a framing error.
    always_ff @(posedge clk_12mhz) begin
        if (reset)
            rx_armed <= 1'b0;
        else if (frame_set)
            rx_armed <= 1'b0;
        else if (sync_vld[1] && rx_s)
            rx_armed <= 1'b1;
    end

    assign rx_stop_sample = (rx_state == S_STOP) && (rx_cnt == BIT_LAST);
    assign frame_set      = rx_stop_sample && !rx_s;
    assign par_set        = rx_stop_sample && HAS_PAR && (rx_par_bit != par_of(rx_shift));
    assign rx_good        = rx_stop_sample && rx_s && !par_set;

    always_ff @(posedge clk_12mhz) begin
        if (reset) begin
            rx_state   <= S_IDLE;
            rx_cnt     <= '0;
            rx_idx     <= '0;
            rx_shift   <= '0;
            rx_par_bit <= 1'b0;
            rx_push    <= 1'b0;
            rx_data    <= '0;
        end else begin
            rx_push <= 1'b0;
            case (rx_state)
                S_IDLE: begin
                    rx_cnt <= '0;
                    if (rx_armed && !rx_s)
                        rx_state <= S_START;
                end
                S_START: begin
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt   <= '0;
                        rx_idx   <= '0;
                        rx_state <= rx_s ? S_IDLE : S_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_s, rx_shift[DATA_BITS-1:1]};
                        if (rx_idx == IDX_LAST)
                            rx_state <= HAS_PAR ? S_PARITY : S_STOP;
                        else
                            rx_idx <= rx_idx + 1'b1;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt     <= '0;
                        rx_par_bit <= rx_s;
                        rx_state   <= S_STOP;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_state <= S_IDLE;
                        if (rx_good) begin
                            rx_push <= 1'b1;
                            rx_data <= rx_shift;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                default: rx_state <= S_IDLE;
            endcase
        end
    end

    // Pop looks at occupancy before this cycle's push, so a fresh byte
    // always spends one cycle in the FIFO.
    assign fifo_empty = (fifo_count == '0);
    assign fifo_full  = (fifo_count == CNT_FULL);
    assign pop        = (tx_state == S_IDLE) && !tx_hold && !fifo_empty;
    assign push       = rx_push && (!fifo_full || pop);
    assign ovf_set    = rx_push && fifo_full && !pop;

    always_ff @(posedge clk_12mhz) begin
        if (push)
            mem[wr_ptr] <= rx_data;
    end

    always_ff @(posedge clk_12mhz) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            if (push && !pop)
                fifo_count <= fifo_count + CNT_ONE;
            else if (pop && !push)
                fifo_count <= fifo_count - CNT_ONE;
        end
    end

    always_ff @(posedge clk_12mhz) begin
        if (reset)
            led <= 8'h00;
        else if (rx_push)
            led <= 8'(rx_data);
    end

    always_ff @(posedge clk_12mhz) begin
        if (reset) begin
            framing_err <= 1'b0;
            parity_err  <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            if (frame_set)
                framing_err <= 1'b1;
            else if (clear_err)
                framing_err <= 1'b0;
            if (par_set)
                parity_err <= 1'b1;
            else if (clear_err)
                parity_err <= 1'b0;
            if (ovf_set)
                overflow <= 1'b1;
            else if (clear_err)
                overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk_12mhz) begin
        if (reset) begin
            tx_state    <= S_IDLE;
            tx_cnt      <= '0;
            tx_idx      <= '0;
            tx_stop_idx <= 1'b0;
            tx_shift    <= '0;
            tx_par      <= 1'b0;
        end else begin
            case (tx_state)
                S_IDLE: begin
                    tx_cnt <= '0;
                    if (pop) begin
                        tx_shift    <= mem[rd_ptr];
                        tx_par      <= par_of(mem[rd_ptr]);
                        tx_idx      <= '0;
                        tx_stop_idx <= 1'b0;
                        tx_state    <= S_START;
                    end
                end
                S_START: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt   <= '0;
                        tx_state <= S_DATA;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt   <= '0;
                        tx_shift <= tx_shift >> 1;
                        if (tx_idx == IDX_LAST)
                            tx_state <= HAS_PAR ? S_PARITY : S_STOP;
                        else
                            tx_idx <= tx_idx + 1'b1;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt   <= '0;
                        tx_state <= S_STOP;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt <= '0;
                        if (tx_stop_idx == STOP_LAST)
                            tx_state <= S_IDLE;
                        else
                            tx_stop_idx <= 1'b1;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                default: tx_state <= S_IDLE;
            endcase
        end
    end

    // txd is registered from the state, so the line trails the FSM by one
    // cycle uniformly and every bit keeps its full width.
    always_ff @(posedge clk_12mhz) begin
        if (reset) begin
            txd <= 1'b1;
        end else begin
            case (tx_state)
                S_START:  txd <= 1'b0;
                S_DATA:   txd <= tx_shift[0];
                S_PARITY: txd <= tx_par;
                default:  txd <= 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_loopback_fifo.sv
// tb/tb_uart_loopback_fifo.sv - directed self-checking bench for uart_loopback_fifo
`timescale 1ns/1ps
module tb_uart_loopback_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       rxd_d, hold_d, clr_d, txd_d, fe_d, pe_d, ov_d;
    logic [7:0] led_d;
    logic [4:0] cnt_d;
    logic       rxd_p, hold_p, clr_p, txd_p, fe_p, pe_p, ov_p;
    logic [7:0] led_p;
    logic [4:0] cnt_p;
    logic       rxd_o, hold_o, clr_o, txd_o, fe_o, pe_o, ov_o;
    logic [7:0] led_o;
    logic [2:0] cnt_o;

    int checks = 0;
    int errors = 0;

    uart_loopback_fifo u_def (
        .clk_12mhz(clk), .reset(reset), .rxd(rxd_d), .tx_hold(hold_d), .clear_err(clr_d),
        .txd(txd_d), .led(led_d), .framing_err(fe_d), .parity_err(pe_d), .overflow(ov_d),
        .fifo_count(cnt_d)
    );

    uart_loopback_fifo #(.PARITY(1)) u_par (
        .clk_12mhz(clk), .reset(reset), .rxd(rxd_p), .tx_hold(hold_p), .clear_err(clr_p),
        .txd(txd_p), .led(led_p), .framing_err(fe_p), .parity_err(pe_p), .overflow(ov_p),
        .fifo_count(cnt_p)
    );

    uart_loopback_fifo #(.FIFO_DEPTH(4)) u_ovf (
        .clk_12mhz(clk), .reset(reset), .rxd(rxd_o), .tx_hold(hold_o), .clear_err(clr_o),
        .txd(txd_o), .led(led_o), .framing_err(fe_o), .parity_err(pe_o), .overflow(ov_o),
        .fifo_count(cnt_o)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_rxd(input int sel, input logic v);
        case (sel)
            0:       rxd_d = v;
            1:       rxd_p = v;
            default: rxd_o = v;
        endcase
    endtask

    function automatic logic get_txd(input int sel);
        case (sel)
            0:       return txd_d;
            1:       return txd_p;
            default: return txd_o;
        endcase
    endfunction

    // Drives start, data and optional parity, then leaves the stop level on the line.
    task automatic send_bits(input int sel, input logic [7:0] d, input bit with_par,
                             input logic pbit, input logic stop);
        set_rxd(sel, 1'b0);
        tick(104);
        for (int i = 0; i < 8; i++) begin
            set_rxd(sel, d[i]);
            tick(104);
        end
        if (with_par) begin
            set_rxd(sel, pbit);
            tick(104);
        end
        set_rxd(sel, stop);
    endtask

    task automatic wait_txd_low(input int sel, input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (get_txd(sel) === 1'b0) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
    endtask

    task automatic capture(input int sel, input bit with_par, input string tag,
                           input logic [7:0] exp_d, input logic exp_p);
        bit         ok;
        logic [7:0] d;
        wait_txd_low(sel, 3000, ok);
        check({tag, "_start_seen"}, 32'(ok), 1);
        tick(52);
        check({tag, "_start_mid"}, 32'(get_txd(sel)), 0);
        for (int i = 0; i < 8; i++) begin
            tick(104);
            d[i] = get_txd(sel);
        end
        check({tag, "_data"}, 32'(d), 32'(exp_d));
        if (with_par) begin
            tick(104);
            check({tag, "_parity"}, 32'(get_txd(sel)), 32'(exp_p));
        end
        tick(104);
        check({tag, "_stop"}, 32'(get_txd(sel)), 1);
    endtask

    initial begin
        bit         found;
        bit         ok;
        int         n;
        int         lows;
        logic [7:0] d;

        reset = 1'b1;
        rxd_d = 1'b1; hold_d = 1'b0; clr_d = 1'b0;
        rxd_p = 1'b1; hold_p = 1'b0; clr_p = 1'b0;
        rxd_o = 1'b1; hold_o = 1'b0; clr_o = 1'b0;
        tick(2);
        check("rst_txd", 32'(txd_d), 1);
        check("rst_led", 32'(led_d), 0);
        check("rst_flags", {29'd0, fe_d, pe_d, ov_d}, 0);
        check("rst_count", 32'(cnt_d), 0);
        reset = 1'b0;
        tick(5);

        // Echo of 0xA5 with exact push/pop/start timing
        send_bits(0, 8'hA5, 1'b0, 1'b0, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick(1);
            if (cnt_d == 5'd1) begin
                found = 1'b1;
                break;
            end
        end
        check("echo_push", 32'(found), 1);
        check("echo_led", 32'(led_d), 32'h A5);
        tick(1);
        check("echo_pop_count", 32'(cnt_d), 0);
        check("echo_txd_n1", 32'(txd_d), 1);
        tick(1);
        check("echo_txd_n2", 32'(txd_d), 0);
        n = 0;
        while (txd_d === 1'b0 && n < 300) begin
            n++;
            tick(1);
        end
        check("echo_start_len", 32'(n), 104);
        for (int i = 0; i < 8; i++) begin
            tick(i == 0 ? 52 : 104);
            d[i] = txd_d;
        end
        check("echo_data", 32'(d), 32'h A5);
        tick(104);
        check("echo_stop", 32'(txd_d), 1);
        check("echo_flags", {29'd0, fe_d, pe_d, ov_d}, 0);

        // Framing error on 0x3C, then clear
        send_bits(0, 8'h3C, 1'b0, 1'b0, 1'b0);
        tick(104);
        rxd_d = 1'b1;
        tick(20);
        check("frm_flag", 32'(fe_d), 1);
        check("frm_count", 32'(cnt_d), 0);
        check("frm_led", 32'(led_d), 32'h A5);
        lows = 0;
        for (int i = 0; i < 300; i++) begin
            tick(1);
            if (txd_d !== 1'b1) lows++;
        end
        check("frm_no_tx", 32'(lows), 0);
        clr_d = 1'b1;
        tick(1);
        clr_d = 1'b0;
        check("frm_cleared", 32'(fe_d), 0);

        // Even parity: 0x07 has three ones, so the correct parity bit is 1
        send_bits(1, 8'h07, 1'b1, 1'b0, 1'b1);
        tick(124);
        check("par_flag", 32'(pe_p), 1);
        check("par_count", 32'(cnt_p), 0);
        check("par_led", 32'(led_p), 0);
        send_bits(1, 8'h07, 1'b1, 1'b1, 1'b1);
        capture(1, 1'b1, "par_echo", 8'h07, 1'b1);
        check("par_no_frm", 32'(fe_p), 0);

        // Overflow on a 4-deep FIFO held off by tx_hold
        hold_o = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            send_bits(2, 8'(i), 1'b0, 1'b0, 1'b1);
            tick(104);
        end
        check("ovf_count", 32'(cnt_o), 4);
        check("ovf_flag", 32'(ov_o), 1);
        check("ovf_led", 32'(led_o), 5);
        hold_o = 1'b0;
        for (int i = 1; i <= 4; i++)
            capture(2, 1'b0, "ovf_echo", 8'(i), 1'b0);
        check("ovf_drained", 32'(cnt_o), 0);
        check("ovf_sticky", 32'(ov_o), 1);

        // 20-cycle low glitch is rejected
        rxd_d = 1'b0;
        tick(20);
        rxd_d = 1'b1;
        tick(150);
        check("glitch_count", 32'(cnt_d), 0);
        check("glitch_flags", {29'd0, fe_d, pe_d, ov_d}, 0);
        check("glitch_led", 32'(led_d), 32'h A5);
        check("glitch_txd", 32'(txd_d), 1);

        // Reset in the middle of a TX frame (bit0 of 0x5A is low)
        send_bits(0, 8'h5A, 1'b0, 1'b0, 1'b1);
        wait_txd_low(0, 300, ok);
        check("rstmid_start_seen", 32'(ok), 1);
        tick(150);
        check("rstmid_pre_txd", 32'(txd_d), 0);
        reset = 1'b1;
        rxd_d = 1'b0;
        tick(1);
        check("rstmid_txd", 32'(txd_d), 1);
        check("rstmid_count", 32'(cnt_d), 0);
        check("rstmid_led", 32'(led_d), 0);
        tick(2);
        reset = 1'b0;
        tick(1100);
        check("rst_low_no_frm", 32'(fe_d), 0);
        check("rst_low_count", 32'(cnt_d), 0);
        check("rst_low_txd", 32'(txd_d), 1);
        rxd_d = 1'b1;
        tick(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
